// File: rtl/id_exe_reg.sv
// ID->EXE pipeline register with freeze, flush/hazard bubble insertion and a
// saturating count of inserted bubbles.
module id_exe_reg #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             freeze,
    input  logic             flush,
    input  logic             hazard,
    input  logic             WB_EN_in,
    input  logic             MEM_R_EN_in,
    input  logic             MEM_W_EN_in,
    input  logic             B_in,
    input  logic             S_in,
    input  logic [3:0]       EXE_CMD_in,
    input  logic [WIDTH-1:0] PC_in,
    input  logic [WIDTH-1:0] Val_Rn_in,
    input  logic [WIDTH-1:0] Val_Rm_in,
    input  logic             imm_in,
    input  logic [11:0]      Shift_operand_in,
    input  logic [23:0]      Signed_imm_24_in,
    input  logic [3:0]       Dest_in,
    input  logic [3:0]       src1_in,
    input  logic [3:0]       src2_in,
    input  logic [3:0]       SR_in,
    output logic             WB_EN_out,
    output logic             MEM_R_EN_out,
    output logic             MEM_W_EN_out,
    output logic             B_out,
    output logic             S_out,
    output logic [3:0]       EXE_CMD_out,
    output logic [WIDTH-1:0] PC_out,
    output logic [WIDTH-1:0] Val_Rn_out,
    output logic [WIDTH-1:0] Val_Rm_out,
    output logic             imm_out,
    output logic [11:0]      Shift_operand_out,
    output logic [23:0]      Signed_imm_24_out,
    output logic [3:0]       Dest_out,
    output logic [3:0]       src1_out,
    output logic [3:0]       src2_out,
    output logic [3:0]       SR_out,
    output logic             valid_out,
    output logic [CNT_W-1:0] bubble_count
);

    logic             wb_en_q, wb_en_d;
    logic             mem_r_en_q, mem_r_en_d;
    logic             mem_w_en_q, mem_w_en_d;
    logic             b_q, b_d;
    logic             s_q, s_d;
    logic [3:0]       exe_cmd_q, exe_cmd_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] val_rn_q, val_rn_d;
    logic [WIDTH-1:0] val_rm_q, val_rm_d;
    logic             imm_q, imm_d;
    logic [11:0]      shift_operand_q, shift_operand_d;
    logic [23:0]      signed_imm_24_q, signed_imm_24_d;
    logic [3:0]       dest_q, dest_d;
    logic [3:0]       src1_q, src1_d;
    logic [3:0]       src2_q, src2_d;
    logic [3:0]       sr_q, sr_d;
    logic             valid_q, valid_d;
    logic [CNT_W-1:0] bubble_count_q, bubble_count_d;

    logic bubble;
    assign bubble = flush | hazard;

    always_comb begin
        wb_en_d         = wb_en_q;
        mem_r_en_d      = mem_r_en_q;
        mem_w_en_d      = mem_w_en_q;
        b_d             = b_q;
        s_d             = s_q;
        exe_cmd_d       = exe_cmd_q;
        pc_d            = pc_q;
        val_rn_d        = val_rn_q;
        val_rm_d        = val_rm_q;
        imm_d           = imm_q;
        shift_operand_d = shift_operand_q;
        signed_imm_24_d = signed_imm_24_q;
        dest_d          = dest_q;
        src1_d          = src1_q;
        src2_d          = src2_q;
        sr_d            = sr_q;
        valid_d         = valid_q;
        bubble_count_d  = bubble_count_q;

        if (!freeze) begin
            // Data fields always follow ID; only the control group is gated by bubbles.
            pc_d            = PC_in;
            val_rn_d        = Val_Rn_in;
            val_rm_d        = Val_Rm_in;
            imm_d           = imm_in;
            shift_operand_d = Shift_operand_in;
            signed_imm_24_d = Signed_imm_24_in;
            dest_d          = Dest_in;
            src1_d          = src1_in;
            src2_d          = src2_in;
            sr_d            = SR_in;

            if (bubble) begin
                wb_en_d    = 1'b0;
                mem_r_en_d = 1'b0;
                mem_w_en_d = 1'b0;
                b_d        = 1'b0;
                s_d        = 1'b0;
                exe_cmd_d  = 4'd0;
                valid_d    = 1'b0;
                if (bubble_count_q != {CNT_W{1'b1}})
                    bubble_count_d = bubble_count_q + CNT_W'(1);
            end else begin
                wb_en_d    = WB_EN_in;
                mem_r_en_d = MEM_R_EN_in;
                mem_w_en_d = MEM_W_EN_in;
                b_d        = B_in;
                s_d        = S_in;
                exe_cmd_d  = EXE_CMD_in;
                valid_d    = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_en_q         <= 1'b0;
            mem_r_en_q      <= 1'b0;
            mem_w_en_q      <= 1'b0;
            b_q             <= 1'b0;
            s_q             <= 1'b0;
            exe_cmd_q       <= '0;
            pc_q            <= '0;
            val_rn_q        <= '0;
            val_rm_q        <= '0;
            imm_q           <= 1'b0;
            shift_operand_q <= '0;
            signed_imm_24_q <= '0;
            dest_q          <= '0;
            src1_q          <= '0;
            src2_q          <= '0;
            sr_q            <= '0;
            valid_q         <= 1'b0;
            bubble_count_q  <= '0;
        end else begin
            wb_en_q         <= wb_en_d;
            mem_r_en_q      <= mem_r_en_d;
            mem_w_en_q      <= mem_w_en_d;
            b_q             <= b_d;
            s_q             <= s_d;
            exe_cmd_q       <= exe_cmd_d;
            pc_q            <= pc_d;
            val_rn_q        <= val_rn_d;
            val_rm_q        <= val_rm_d;
            imm_q           <= imm_d;
            shift_operand_q <= shift_operand_d;
            signed_imm_24_q <= signed_imm_24_d;
            dest_q          <= dest_d;
            src1_q          <= src1_d;
            src2_q          <= src2_d;
            sr_q            <= sr_d;
            valid_q         <= valid_d;
            bubble_count_q  <= bubble_count_d;
        end
    end

    assign WB_EN_out         = wb_en_q;
    assign MEM_R_EN_out      = mem_r_en_q;
    assign MEM_W_EN_out      = mem_w_en_q;
    assign B_out             = b_q;
    assign S_out             = s_q;
    assign EXE_CMD_out       = exe_cmd_q;
    assign PC_out            = pc_q;
    assign Val_Rn_out        = val_rn_q;
    assign Val_Rm_out        = val_rm_q;
    assign imm_out           = imm_q;
    assign Shift_operand_out = shift_operand_q;
    assign Signed_imm_24_out = signed_imm_24_q;
    assign Dest_out          = dest_q;
    assign src1_out          = src1_q;
    assign src2_out          = src2_q;
    assign SR_out            = sr_q;
    assign valid_out         = valid_q;
    assign bubble_count      = bubble_count_q;

endmodule

// File: tb/tb_id_exe_reg.sv
// Directed bench for id_exe_reg: reset, load, bubbles, freeze priority,
// counter saturation (narrow counter instance) and mid-cycle reset.
module tb_id_exe_reg;

    logic        clk = 1'b0;
    logic        rst;
    logic        freeze, flush, hazard;
    logic        wb_en_in, mem_r_en_in, mem_w_en_in, b_in, s_in, imm_in;
    logic [3:0]  exe_cmd_in, dest_in, src1_in, src2_in, sr_in;
    logic [31:0] pc_in, val_rn_in, val_rm_in;
    logic [11:0] shift_in;
    logic [23:0] simm_in;

    logic        wb_en_o, mem_r_en_o, mem_w_en_o, b_o, s_o, imm_o, valid_o;
    logic [3:0]  exe_cmd_o, dest_o, src1_o, src2_o, sr_o;
    logic [31:0] pc_o, val_rn_o, val_rm_o;
    logic [11:0] shift_o;
    logic [23:0] simm_o;
    logic [15:0] bcnt;

    logic        n_wb, n_mr, n_mw, n_b, n_s, n_imm, n_valid;
    logic [3:0]  n_cmd, n_dest, n_src1, n_src2, n_sr;
    logic [31:0] n_pc, n_rn, n_rm;
    logic [11:0] n_shift;
    logic [23:0] n_simm;
    logic [3:0]  n_bcnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    id_exe_reg #(.WIDTH(32), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .freeze(freeze), .flush(flush), .hazard(hazard),
        .WB_EN_in(wb_en_in), .MEM_R_EN_in(mem_r_en_in), .MEM_W_EN_in(mem_w_en_in),
        .B_in(b_in), .S_in(s_in), .EXE_CMD_in(exe_cmd_in), .PC_in(pc_in),
        .Val_Rn_in(val_rn_in), .Val_Rm_in(val_rm_in), .imm_in(imm_in),
        .Shift_operand_in(shift_in), .Signed_imm_24_in(simm_in), .Dest_in(dest_in),
        .src1_in(src1_in), .src2_in(src2_in), .SR_in(sr_in),
        .WB_EN_out(wb_en_o), .MEM_R_EN_out(mem_r_en_o), .MEM_W_EN_out(mem_w_en_o),
        .B_out(b_o), .S_out(s_o), .EXE_CMD_out(exe_cmd_o), .PC_out(pc_o),
        .Val_Rn_out(val_rn_o), .Val_Rm_out(val_rm_o), .imm_out(imm_o),
        .Shift_operand_out(shift_o), .Signed_imm_24_out(simm_o), .Dest_out(dest_o),
        .src1_out(src1_o), .src2_out(src2_o), .SR_out(sr_o),
        .valid_out(valid_o), .bubble_count(bcnt)
    );

    // Narrow-counter instance sharing the same stimulus, used for saturation.
    id_exe_reg #(.WIDTH(32), .CNT_W(4)) dut_n (
        .clk(clk), .rst(rst), .freeze(freeze), .flush(flush), .hazard(hazard),
        .WB_EN_in(wb_en_in), .MEM_R_EN_in(mem_r_en_in), .MEM_W_EN_in(mem_w_en_in),
        .B_in(b_in), .S_in(s_in), .EXE_CMD_in(exe_cmd_in), .PC_in(pc_in),
        .Val_Rn_in(val_rn_in), .Val_Rm_in(val_rm_in), .imm_in(imm_in),
        .Shift_operand_in(shift_in), .Signed_imm_24_in(simm_in), .Dest_in(dest_in),
        .src1_in(src1_in), .src2_in(src2_in), .SR_in(sr_in),
        .WB_EN_out(n_wb), .MEM_R_EN_out(n_mr), .MEM_W_EN_out(n_mw),
        .B_out(n_b), .S_out(n_s), .EXE_CMD_out(n_cmd), .PC_out(n_pc),
        .Val_Rn_out(n_rn), .Val_Rm_out(n_rm), .imm_out(n_imm),
        .Shift_operand_out(n_shift), .Signed_imm_24_out(n_simm), .Dest_out(n_dest),
        .src1_out(n_src1), .src2_out(n_src2), .SR_out(n_sr),
        .valid_out(n_valid), .bubble_count(n_bcnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_ctrl(input logic wb, input logic mr, input logic mw,
                            input logic b, input logic s, input logic [3:0] cmd,
                            input logic [3:0] dest, input logic [31:0] pc);
        wb_en_in    = wb;
        mem_r_en_in = mr;
        mem_w_en_in = mw;
        b_in        = b;
        s_in        = s;
        exe_cmd_in  = cmd;
        dest_in     = dest;
        pc_in       = pc;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; freeze = 1'b0; flush = 1'b0; hazard = 1'b0;
        set_ctrl(1, 1, 1, 1, 1, 4'hF, 4'hE, 32'hDEAD_BEEF);
        val_rn_in = 32'h1234_5678; val_rm_in = 32'h8765_4321; imm_in = 1'b1;
        shift_in = 12'hFFF; simm_in = 24'hFF_FFFF; src1_in = 4'h9; src2_in = 4'h8;
        sr_in = 4'hF;
        tick(); tick();

        // reset with nonzero inputs
        check("rst_wb", wb_en_o, 0);
        check("rst_mr", mem_r_en_o, 0);
        check("rst_mw", mem_w_en_o, 0);
        check("rst_cmd", exe_cmd_o, 0);
        check("rst_pc", pc_o, 0);
        check("rst_rn", val_rn_o, 0);
        check("rst_simm", simm_o, 0);
        check("rst_sr", sr_o, 0);
        check("rst_valid", valid_o, 0);
        check("rst_bcnt", bcnt, 0);

        // first load after release
        @(negedge clk);
        rst = 1'b0;
        set_ctrl(1, 0, 0, 0, 0, 4'b0010, 4'd5, 32'h100);
        val_rn_in = 0; val_rm_in = 0; imm_in = 0; shift_in = 0; simm_in = 0;
        src1_in = 0; src2_in = 0; sr_in = 0;
        tick();
        check("ld_cmd", exe_cmd_o, 2);
        check("ld_wb", wb_en_o, 1);
        check("ld_dest", dest_o, 5);
        check("ld_valid", valid_o, 1);
        check("ld_pc", pc_o, 32'h100);

        // hazard bubble: controls clear, data loads
        @(negedge clk);
        hazard = 1'b1;
        set_ctrl(1, 0, 1, 1, 1, 4'hA, 4'd7, 32'h104);
        val_rn_in = 32'h11; val_rm_in = 32'h22; imm_in = 1'b1; shift_in = 12'hABC;
        simm_in = 24'h12_3456; src1_in = 4'd3; src2_in = 4'd4; sr_in = 4'b1010;
        tick();
        check("hz_wb", wb_en_o, 0);
        check("hz_mw", mem_w_en_o, 0);
        check("hz_b", b_o, 0);
        check("hz_s", s_o, 0);
        check("hz_cmd", exe_cmd_o, 0);
        check("hz_valid", valid_o, 0);
        check("hz_dest", dest_o, 7);
        check("hz_pc", pc_o, 32'h104);
        check("hz_shift", shift_o, 12'hABC);
        check("hz_simm", simm_o, 24'h12_3456);
        check("hz_sr", sr_o, 4'b1010);
        check("hz_bcnt", bcnt, 1);

        // normal load of the same instruction
        @(negedge clk);
        hazard = 1'b0;
        tick();
        check("nl_wb", wb_en_o, 1);
        check("nl_mw", mem_w_en_o, 1);
        check("nl_mr", mem_r_en_o, 0);
        check("nl_b", b_o, 1);
        check("nl_s", s_o, 1);
        check("nl_cmd", exe_cmd_o, 4'hA);
        check("nl_valid", valid_o, 1);
        check("nl_rn", val_rn_o, 32'h11);
        check("nl_rm", val_rm_o, 32'h22);
        check("nl_imm", imm_o, 1);
        check("nl_src1", src1_o, 3);
        check("nl_src2", src2_o, 4);
        check("nl_bcnt", bcnt, 1);

        // freeze overrides flush for 3 cycles
        @(negedge clk);
        freeze = 1'b1; flush = 1'b1;
        set_ctrl(0, 1, 0, 0, 0, 4'd3, 4'd9, 32'h200);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("fz_cmd", exe_cmd_o, 4'hA);
            check("fz_valid", valid_o, 1);
            check("fz_dest", dest_o, 7);
            check("fz_pc", pc_o, 32'h104);
            check("fz_bcnt", bcnt, 1);
        end

        // freeze drops: pending flush takes effect
        @(negedge clk);
        freeze = 1'b0;
        tick();
        check("fl_valid", valid_o, 0);
        check("fl_cmd", exe_cmd_o, 0);
        check("fl_mr", mem_r_en_o, 0);
        check("fl_dest", dest_o, 9);
        check("fl_pc", pc_o, 32'h200);
        check("fl_bcnt", bcnt, 2);

        // flush and hazard together count once
        @(negedge clk);
        hazard = 1'b1;
        tick();
        check("fh_valid", valid_o, 0);
        check("fh_bcnt", bcnt, 3);
        check("fh_bcnt_n", n_bcnt, 3);

        // 20 more bubbles: narrow counter saturates at 15
        @(negedge clk);
        flush = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        check("sat_bcnt_n", n_bcnt, 15);
        check("sat_bcnt", bcnt, 23);

        // load with MEM_R_EN, then reset between edges
        @(negedge clk);
        hazard = 1'b0;
        set_ctrl(0, 1, 0, 0, 0, 4'd5, 4'd10, 32'h300);
        tick();
        check("pr_valid", valid_o, 1);
        check("pr_mr", mem_r_en_o, 1);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("ar_valid", valid_o, 0);
        check("ar_mr", mem_r_en_o, 0);
        check("ar_cmd", exe_cmd_o, 0);
        check("ar_bcnt", bcnt, 0);
        check("ar_bcnt_n", n_bcnt, 0);
        #1 rst = 1'b0;
        set_ctrl(1, 0, 0, 0, 0, 4'd6, 4'd12, 32'h400);
        tick();
        check("rl_cmd", exe_cmd_o, 6);
        check("rl_wb", wb_en_o, 1);
        check("rl_dest", dest_o, 12);
        check("rl_pc", pc_o, 32'h400);
        check("rl_valid", valid_o, 1);
        check("rl_bcnt", bcnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
